// File: rtl/clock_step_ctrl.sv
// clock_step_ctrl: generates the CPU clock-enable, reset and halt controls from the oscillator,
// the front-panel inputs and datapath feedback (run, cycle step, instruction step, breakpoint).
module clock_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int RUN_DIV         = 4,
    parameter int RESET_HOLD      = 8
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_btnStep,
    input  logic i_btnReset,
    input  logic i_swInstrNCycle,
    input  logic i_swStepNRun,
    input  logic i_swEnableBreakpoint,
    input  logic i_ctrlInstrFinishedN,
    input  logic i_breakpointHitN,
    output logic o_cpuClkEn,
    output logic o_cpuResetn,
    output logic o_breakpointEnableN,
    output logic o_halt
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DVW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    localparam int RHW = $clog2(RESET_HOLD + 1);

    typedef enum logic [2:0] {S_RESET, S_HALTED, S_STEP_INSTR, S_RUN, S_BREAK} state_t;

    // bit order: {bp enable, step mode, instr mode, reset button, step button}
    logic [4:0] raw, sync1_q, sync2_q, deb;
    logic [1:0] ev_prev_q;
    logic step_req, mode_fall, running, tick, bp_stop, pulse, armed_q, armed_d;
    state_t state_q, state_d;
    logic [DVW-1:0] div_q, div_d;
    logic [RHW-1:0] rst_cnt_q, rst_cnt_d;

    assign raw = {i_swEnableBreakpoint, i_swStepNRun, i_swInstrNCycle, i_btnReset, i_btnStep};

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) {sync2_q, sync1_q} <= '0;
        else {sync2_q, sync1_q} <= {sync1_q, raw};
    end

    for (genvar i = 0; i < 5; i++) begin : g_db
        logic [DBW-1:0] cnt_q;
        logic deb_q;
        always_ff @(posedge i_clk or negedge i_resetn) begin
            if (!i_resetn) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else if (sync2_q[i] == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q <= '0;
                deb_q <= sync2_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign deb[i] = deb_q;
    end

    assign step_req  = deb[0] & ~ev_prev_q[0];
    assign mode_fall = ~deb[3] & ev_prev_q[1];

    // Halted-like states leave for RUN only on a run-mode selection event, so a breakpoint
    // stop holds even while the switch sits in run mode.
    always_comb begin
        running   = state_q inside {S_RUN, S_STEP_INSTR};
        tick      = running && div_q == DVW'(RUN_DIV - 1);
        bp_stop   = tick && !o_breakpointEnableN && !i_breakpointHitN;
        state_d   = state_q;
        rst_cnt_d = '0;
        armed_d   = armed_q;
        pulse     = 1'b0;
        if (deb[1]) state_d = S_RESET;
        else if (state_q == S_RESET) begin
            rst_cnt_d = rst_cnt_q + 1'b1;
            if (rst_cnt_q == RHW'(RESET_HOLD - 1)) state_d = deb[3] ? S_HALTED : S_RUN;
        end else if (bp_stop) begin
            state_d = S_BREAK;
            armed_d = 1'b0;
        end else if (state_q == S_RUN && deb[3]) state_d = S_HALTED;
        else if (state_q != S_RUN && mode_fall) state_d = S_RUN;
        else if (running) begin
            pulse = tick;
            if (tick && state_q == S_STEP_INSTR && !i_ctrlInstrFinishedN) state_d = S_HALTED;
        end else if (step_req) begin
            pulse = !deb[2];
            if (deb[2]) state_d = S_STEP_INSTR;
        end
        if (pulse && !i_ctrlInstrFinishedN) armed_d = 1'b1;
        div_d = (state_d == state_q && running && !tick) ? div_q + 1'b1 : '0;
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q             <= S_RESET;
            div_q               <= '0;
            rst_cnt_q           <= '0;
            armed_q             <= 1'b1;
            ev_prev_q           <= '0;
            o_cpuClkEn          <= 1'b0;
            o_cpuResetn         <= 1'b0;
            o_halt              <= 1'b1;
            o_breakpointEnableN <= 1'b1;
        end else begin
            state_q             <= state_d;
            div_q               <= div_d;
            rst_cnt_q           <= rst_cnt_d;
            armed_q             <= armed_d;
            ev_prev_q           <= {deb[3], deb[0]};
            o_cpuClkEn          <= pulse;
            o_cpuResetn         <= state_d != S_RESET;
            o_halt              <= !(state_d inside {S_RUN, S_STEP_INSTR});
            o_breakpointEnableN <= !(deb[4] && armed_d);
        end
    end
endmodule
